// File: rtl/tx_split_pkg.sv
// Shared constants and types for the split-transaction sighash front end.
package tx_split_pkg;

  localparam int unsigned TX_BYTES = 420;
  localparam int unsigned TX_W     = 3361;
  // Index of the final byte of a frame.
  localparam logic [8:0]  LAST_IDX = 9'(TX_BYTES - 1);

  // Transaction vector field map (bit 3360 is an always-zero pad).
  localparam int unsigned NVERSION_MSB      = 3359;
  localparam int unsigned NVERSION_LSB      = 3328;
  localparam int unsigned HASH_PREVOUTS_MSB = 3327;
  localparam int unsigned HASH_PREVOUTS_LSB = 3072;
  localparam int unsigned HASH_SEQUENCE_MSB = 3071;
  localparam int unsigned HASH_SEQUENCE_LSB = 2816;
  localparam int unsigned IN_TXID_MSB       = 2815;
  localparam int unsigned IN_TXID_LSB       = 2560;
  localparam int unsigned IN_VOUT_MSB       = 2559;
  localparam int unsigned IN_VOUT_LSB       = 2528;
  localparam int unsigned SCRIPT_MSB        = 2527;
  localparam int unsigned SCRIPT_LSB        = 656;
  localparam int unsigned IN_AMOUNT_MSB     = 655;
  localparam int unsigned IN_AMOUNT_LSB     = 592;
  localparam int unsigned IN_NSEQ_MSB       = 591;
  localparam int unsigned IN_NSEQ_LSB       = 560;
  localparam int unsigned LOCKTIME_MSB      = 559;
  localparam int unsigned LOCKTIME_LSB      = 528;
  localparam int unsigned SIGHASH_MSB       = 527;
  localparam int unsigned SIGHASH_LSB       = 496;
  localparam int unsigned OUT0_MSB          = 495;
  localparam int unsigned OUT0_LSB          = 248;
  localparam int unsigned OUT1_MSB          = 247;
  localparam int unsigned OUT1_LSB          = 0;

  localparam logic [31:0] SIGHASH_ALL_LE = 32'h01000000;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrShort   = 2'd1,
    ErrOverrun = 2'd2,
    ErrSighash = 2'd3
  } err_code_e;

  // Loader FSM states.
  localparam logic [1:0] StRecv  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

endpackage

// File: rtl/tx_stream_loader.sv
// Byte-serial loader: assembles a 420-byte frame into the sighash transaction
// vector, validates length and sighash type, and holds it under valid/ready.
module tx_stream_loader
  import tx_split_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [TX_W-1:0] tx,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            err,
  output logic [1:0]      err_code
);

  logic [1:0]      state_q, state_d;
  logic [8:0]      count_q, count_d;
  logic [TX_W-1:0] tx_q, tx_d;
  logic            in_ready_q, in_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic            err_q, err_d;
  err_code_e       err_code_q, err_code_d;

  logic            accept;
  logic [11:0]     bit_idx;

  assign accept  = in_valid && in_ready_q;
  // MSB of the byte slot addressed by the current count; byte 0 lands at 3359.
  assign bit_idx = 12'(TX_W - 2) - {count_q, 3'b000};

  // Next-state: byte write decode, counter and frame FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tx_d       = tx_q;
    err_d      = 1'b0;
    err_code_d = ErrNone;

    case (state_q)
      StRecv: begin
        if (accept) begin
          tx_d[bit_idx -: 8] = in_data;
          if (count_q < LAST_IDX) begin
            if (in_last) begin
              err_d      = 1'b1;
              err_code_d = ErrShort;
              count_d    = '0;
            end else begin
              count_d = count_q + 9'd1;
            end
          end else begin
            count_d = '0;
            if (!in_last) begin
              err_d      = 1'b1;
              err_code_d = ErrOverrun;
              state_d    = StDrain;
            // Sighash bytes 354..357 are already in tx_q by the time byte 419 arrives.
            end else if (tx_q[SIGHASH_MSB:SIGHASH_LSB] == SIGHASH_ALL_LE) begin
              state_d = StFull;
            end else begin
              err_d      = 1'b1;
              err_code_d = ErrSighash;
            end
          end
        end
      end
      StDrain: begin
        if (accept && in_last) begin
          state_d = StRecv;
          count_d = '0;
        end
      end
      StFull: begin
        if (tx_valid_q && tx_ready) begin
          state_d = StRecv;
        end
      end
      default: begin
        state_d = StRecv;
        count_d = '0;
      end
    endcase

    // Handshake outputs are registered so they follow the state one cycle later.
    in_ready_d = (state_d != StFull);
    tx_valid_d = (state_d == StFull);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRecv;
      count_q    <= '0;
      tx_q       <= '0;
      in_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx       = tx_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: doc/tx_stream_loader.md
Name: tx_stream_loader

Overview:
- Byte-serial front end for the split-transaction sighash datapath. It sits directly upstream of the split sighash unit.
- Accepts one serialized signing transaction per frame over a valid/ready byte stream. Assembles the frame into the 3361-bit transaction vector the sighash unit consumes.
- Validates frame length and sighash type, then holds the vector stable under a valid/ready handshake until it is consumed.

Parameters:
- TX_BYTES, 420, bytes per frame (3360 payload bits).
- SIGHASH_ALL_LE, 32'h01000000, required value of the sighash_type field (bits [527:496]).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  marks the final byte of a frame; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- tx  out  3361  assembled transaction; bit 3360 is always 0.
- tx_valid  out  1  tx holds a complete, validated frame.
- tx_ready  in  1  downstream consumes tx.
- err  out  1  single-cycle error pulse.
- err_code  out  2  error cause, valid while err=1: 1=short frame, 2=overrun, 3=bad sighash type.

Behaviour:
- Reset values: tx=0, tx_valid=0, in_ready=0, err=0, err_code=0, byte count=0, state=RECV. in_ready rises the cycle after rst deasserts.
- Byte accepted when in_valid && in_ready. Byte index k goes to tx[3359-8k -: 8]: first byte lands in nversion MSBs, byte 419 lands in tx[7:0]. Count is 9 bits and saturates logically at 419.
- States:
  - RECV: in_ready=1.
    - Accept at k<419 with in_last=1: err=1, err_code=1 next cycle; count cleared; stay RECV.
    - Accept at k=419 with in_last=0: err=1, err_code=2 next cycle; go to DRAIN.
    - Accept at k=419 with in_last=1: check the sighash_type field, using the already-written bytes 354..357 (complete before byte 419).
      - Field == SIGHASH_ALL_LE: go to FULL; tx_valid=1 next cycle.
      - Otherwise: err=1, err_code=3 next cycle; count cleared; stay RECV.
  - DRAIN: in_ready=1. Discard bytes, tx not written. On accept with in_last=1, go to RECV with count=0.
  - FULL: in_ready=0, tx_valid=1, tx stable. On tx_valid && tx_ready, go to RECV: tx_valid=0 and in_ready=1 next cycle. There is no same-cycle accept-and-release; there is at least one idle cycle between frames.
- Latency: tx_valid rises one cycle after the last byte is accepted. Minimum frame period is 422 cycles (420 accepts + 1 FULL cycle + 1 release).
- tx is not cleared between frames; partially overwritten content is not observable because tx_valid=0.
- err is high for exactly one cycle per error, never simultaneously with tx_valid rising. Errors never assert tx_valid.
- rst mid-frame (any state) discards everything and returns all outputs to reset values on the next edge. in_valid during rst is ignored.
- in_last with in_valid=0 is ignored.

Decomposition:
- Shared package tx_split_pkg:
  - TX_BYTES, TX_W=3361.
  - Field MSB/LSB constants for nversion, hash_prevouts, hash_sequence, in_txid, in_vout, script, in_amount, in_nseq, locktime, sighash_type, and the two 248-bit output records.
  - SIGHASH_ALL_LE.
  - Error-code enum.
  - State enum {RECV, DRAIN, FULL}.
- No sub-module. Byte-write decode, counter and FSM stay in one block.

Test Plan:
- Nominal frame: 420 bytes with byte k = k[7:0] and bytes 354..357 = 01 00 00 00, no stalls, tx_ready=1 -> tx_valid for exactly 1 cycle. Check tx[3359:3352]=8'h00, tx[7:0]=8'hA3, tx[527:496]=32'h01000000, tx[3360]=0, err never asserted.
- Backpressure: tx_ready=0 for 50 cycles after completion -> tx_valid and tx held stable, in_ready=0 throughout. Release with tx_ready=1 -> in_ready=1 on the following cycle.
- Short frame: in_last on byte 100 -> err=1, err_code=1 for one cycle, no tx_valid. A subsequent valid frame is accepted correctly from byte 0.
- Overrun: 425 bytes with in_last on the last one -> err_code=2 pulse after byte 419; bytes 420..424 are accepted and discarded. The next valid frame completes normally.
- Bad sighash type: bytes 354..357 = 02 00 00 00 -> err_code=3 pulse and no tx_valid. Random in_valid gaps (~30% duty) on a valid frame still produce a correct tx.
- Reset at byte 200 -> outputs return to reset values; a full 420-byte frame sent afterwards is captured exactly.
